// File: rtl/fifo_drain_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_drain_ctrl
// Read-side sequencer for the sample FIFO. The FIFO has a 1-cycle registered
// read and no level output. This block pops samples in bursts of up to
// BURST_LEN words and presents them on a valid/ready stream with first/last
// framing. It also counts writes the FIFO dropped because it was full.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   enable_i         allow new bursts (sampled only while idle)
//   fifo_empty_i     FIFO empty flag
//   fifo_full_i      FIFO full flag
//   fifo_wr_en_i     FIFO write enable (monitored for overflow only)
//   fifo_rd_en_o     single-cycle pop strobe to the FIFO
//   fifo_rd_data_i   FIFO read data, valid the cycle after fifo_rd_en_o
//   m_valid_o/m_ready_i/m_data_o/m_first_o/m_last_o   output beat stream
//   busy_o           high whenever a burst is in progress
//   clr_ovf_i        synchronous clear of the overflow counter
//   ovf_cnt_o        saturating count of dropped writes
// ---------------------------------------------------------------------------
module fifo_drain_ctrl #(
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_i,
    input  logic                 fifo_empty_i,
    input  logic                 fifo_full_i,
    input  logic                 fifo_wr_en_i,
    output logic                 fifo_rd_en_o,
    input  logic [WIDTH-1:0]     fifo_rd_data_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [WIDTH-1:0]     m_data_o,
    output logic                 m_first_o,
    output logic                 m_last_o,
    output logic                 busy_o,
    input  logic                 clr_ovf_i,
    output logic [CNT_WIDTH-1:0] ovf_cnt_o
);

    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_SEND    = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   first_q, first_d;
    logic                   last_q, last_d;
    logic                   rd_en_q, rd_en_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic [CNT_WIDTH-1:0]   ovf_q, ovf_d;

    // State and output registers; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            data_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            data_q  <= data_d;
            first_q <= first_d;
            last_q  <= last_d;
            rd_en_q <= rd_en_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic. A not-last beat implies the FIFO still holds data,
    // since this block is its only reader, so SEND may go straight to READ.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable_i && !fifo_empty_i) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ:    state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_SEND;
            ST_SEND: begin
                if (valid_q && m_ready_i) begin
                    state_d = last_q ? ST_IDLE : ST_READ;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values. Strobes are decoded from the next state so
    // the registered outputs line up with the state they describe.
    always_comb begin
        beat_d  = beat_q;
        data_d  = data_q;
        first_d = first_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (state_d == ST_READ) begin
                    beat_d = '0;
                end else begin
                    beat_d = beat_q;
                end
            end
            ST_CAPTURE: begin
                // fifo_empty_i here already reflects the pop just performed.
                data_d  = fifo_rd_data_i;
                first_d = (beat_q == '0);
                last_d  = (beat_q == LAST_BEAT) || fifo_empty_i;
            end
            ST_SEND: begin
                if (state_d == ST_READ) begin
                    beat_d = beat_q + BEAT_W'(1);
                end else begin
                    beat_d = beat_q;
                end
            end
            default: beat_d = beat_q;
        endcase
        rd_en_d = (state_d == ST_READ);
        valid_d = (state_d == ST_SEND);
        busy_d  = (state_d != ST_IDLE);
    end

    // Overflow counter next value: clear wins, otherwise saturating increment.
    always_comb begin
        if (clr_ovf_i) begin
            ovf_d = '0;
        end else if (fifo_wr_en_i && fifo_full_i && (ovf_q != CNT_MAX)) begin
            ovf_d = ovf_q + CNT_WIDTH'(1);
        end else begin
            ovf_d = ovf_q;
        end
    end

    assign fifo_rd_en_o = rd_en_q;
    assign m_valid_o    = valid_q;
    assign m_data_o     = data_q;
    assign m_first_o    = first_q;
    assign m_last_o     = last_q;
    assign busy_o       = busy_q;
    assign ovf_cnt_o    = ovf_q;

endmodule
